// File: rtl/key_pkg.sv
// Shared constants and helpers for the key debouncer.
// Defaults assume a 50 MHz clk.
package key_pkg;

    localparam int KEY_COUNT           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;      // 1 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;   // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 10000000;   // 200 ms

    // Repeat counter phase: waiting for the first repeat, then periodic repeats.
    typedef enum logic {
        RPT_DELAY  = 1'b0,
        RPT_PERIOD = 1'b1
    } rpt_phase_e;

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key bus: raw active-low buttons in, debounced levels and press pulses out.
interface key_debounce_if
    import key_pkg::*;
#(
    parameter int WIDTH = KEY_COUNT
);
    logic [WIDTH-1:0] key_n;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] press;

    // Button side drives raw levels and watches the clean outputs.
    modport master (output key_n, input key, input press);
    // Debouncer side.
    modport slave  (input key_n, output key, output press);
endinterface

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchronizer, stability counter, debounced level and
// press pulse. Defining KEY_DEBOUNCE_AUTOREPEAT_EN adds a repeat counter that
// regenerates press pulses while the key is held.
//
// Repeat phase (auto-repeat builds only)
//   state      | meaning
//   RPT_DELAY  | key held, waiting REPEAT_DELAY cycles since the accepted press
//   RPT_PERIOD | key held, pulsing every REPEAT_PERIOD cycles
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_key_n,
    output logic o_key,
    output logic o_press
);
    localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_debounce_channel: DEBOUNCE_CYCLES must be >= 2, REPEAT_* >= 1");
    end

    logic            r_sync1;
    logic            r_sync2;
    logic            r_key;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;
    logic            w_s;
    logic            w_differ;
    logic            w_accept;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] r_rpt_cnt;
    rpt_phase_e       r_rpt_phase;
    logic [RPT_W-1:0] w_rpt_last;

    assign w_rpt_last = (r_rpt_phase == RPT_DELAY) ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
`endif

    assign w_s      = ~r_sync2;
    assign w_differ = (w_s != r_key);
    assign w_accept = w_differ && (r_cnt == DB_LAST);

    // Bring the asynchronous button level into the clock domain; idle is released.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
    // pulse press on acceptance of a press (and on repeats when enabled).
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_key   <= 1'b0;
            r_press <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            r_rpt_cnt   <= '0;
            r_rpt_phase <= RPT_DELAY;
`endif
        end else begin
            r_press <= 1'b0;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_key   <= w_s;
                r_press <= w_s;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            // A fresh press restarts the delay; a release (or idle key) holds it clear,
            // so the release cycle can never carry a repeat pulse.
            if (w_accept || !r_key) begin
                r_rpt_cnt   <= '0;
                r_rpt_phase <= RPT_DELAY;
            end else if (r_rpt_cnt == w_rpt_last) begin
                r_rpt_cnt   <= '0;
                r_rpt_phase <= RPT_PERIOD;
                r_press     <= 1'b1;
            end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
`endif
        end
    end

    assign o_key   = r_key;
    assign o_press = r_press;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: WIDTH independent debounce channels behind the key bus.
// Auto-repeat is built in when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
module key_debounce
    import key_pkg::*;
#(
    parameter int WIDTH           = KEY_COUNT,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic          i_clock,
    input  logic          i_reset,
    key_debounce_if.slave bus
);
    logic [WIDTH-1:0] w_key;
    logic [WIDTH-1:0] w_press;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_key_n (bus.key_n[g]),
            .o_key   (w_key[g]),
            .o_press (w_press[g])
        );
    end

    assign bus.key   = w_key;
    assign bus.press = w_press;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Follows KEY_DEBOUNCE_AUTOREPEAT_EN to pick the expected repeat behaviour.
module tb_key_debounce;
    import key_pkg::*;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    key_debounce_if #(.WIDTH(KEY_COUNT)) bus();

    key_debounce #(
        .WIDTH           (KEY_COUNT),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw levels reach the logic two edges late; a key takes the
    // new level once the last DC delayed samples all disagree with it.
    logic [3:0] raw_q[$];
    logic [3:0] s_hist[$];
    logic [3:0] m_key;
    logic [3:0] m_press;
    int         since[4];

    function automatic void model_reset();
        raw_q.delete();
        raw_q.push_back(4'hF);
        raw_q.push_back(4'hF);
        s_hist.delete();
        m_key   = 4'h0;
        m_press = 4'h0;
        for (int i = 0; i < 4; i++) since[i] = 0;
    endfunction

    function automatic void model_edge(input logic rst_v, input logic [3:0] kn);
        logic [3:0] s;
        logic       old;
        bit         all_diff;
        if (rst_v) begin
            model_reset();
            return;
        end
        s = ~raw_q.pop_front();
        raw_q.push_back(kn);
        s_hist.push_back(s);
        if (s_hist.size() > DC) void'(s_hist.pop_front());
        m_press = 4'h0;
        for (int i = 0; i < 4; i++) begin
            old = m_key[i];
            if (s_hist.size() == DC) begin
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++)
                    if (s_hist[j][i] == old) all_diff = 1'b0;
                if (all_diff) m_key[i] = s[i];
            end
            if (!old && m_key[i]) begin
                m_press[i] = 1'b1;
                since[i]   = 0;
            end else if (m_key[i]) begin
                since[i]++;
                if (AR && since[i] >= RD && ((since[i] - RD) % RP) == 0)
                    m_press[i] = 1'b1;
            end else begin
                since[i] = 0;
            end
        end
    endfunction

    // One clock: model sees the inputs present at the edge; outputs sampled 2 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge(rst, bus.key_n);
        #2;
    endtask

    task automatic test_reset();
        logic [3:0] ek, ep;
        rst = 1'b1;
        bus.key_n = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (bus.key !== 4'b0000 || bus.press !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold: key=%b press=%b, expected key=0000 press=0000", bus.key, bus.press);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            ek = (e >= 6) ? 4'hF : 4'h0;
            ep = (e == 6) ? 4'hF : 4'h0;
            n_tests++;
            if (bus.key !== ek || bus.press !== ep) begin
                n_fail++;
                $display("FAIL reset_release e%0d: key=%b press=%b, expected key=%b press=%b", e, bus.key, bus.press, ek, ep);
            end
            n_tests++;
            if (bus.key !== m_key || bus.press !== m_press) begin
                n_fail++;
                $display("FAIL model_reset e%0d: key=%b press=%b, expected key=%b press=%b", e, bus.key, bus.press, m_key, m_press);
            end
        end
        bus.key_n = 4'hF;
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_tests++;
            if (bus.key !== m_key || bus.press !== m_press) begin
                n_fail++;
                $display("FAIL model_release_all e%0d: key=%b press=%b, expected key=%b press=%b", e, bus.key, bus.press, m_key, m_press);
            end
        end
        n_tests++;
        if (bus.key !== 4'h0) begin
            n_fail++;
            $display("FAIL release_all: key=%b, expected key=0000", bus.key);
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] ek, ep;
        bus.key_n = 4'b1110;
        for (int e = 1; e <= 8; e++) begin
            tick();
            ek = (e >= 6) ? 4'b0001 : 4'b0000;
            ep = (e == 6) ? 4'b0001 : 4'b0000;
            n_tests++;
            if (bus.key !== ek || bus.press !== ep) begin
                n_fail++;
                $display("FAIL clean_press e%0d: key=%b press=%b, expected key=%b press=%b", e, bus.key, bus.press, ek, ep);
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] ek;
        bus.key_n = 4'b1111;
        for (int e = 1; e <= 7; e++) begin
            tick();
            ek = (e >= 6) ? 4'b0000 : 4'b0001;
            n_tests++;
            if (bus.key !== ek || bus.press !== 4'b0000) begin
                n_fail++;
                $display("FAIL release e%0d: key=%b press=%b, expected key=%b press=0000", e, bus.key, bus.press, ek);
            end
        end
    endtask

    task automatic test_bounce();
        logic low;
        for (int e = 1; e <= 15; e++) begin
            low = (e <= 3) || (e >= 5 && e <= 7);
            bus.key_n = low ? 4'b1101 : 4'b1111;
            tick();
            n_tests++;
            if (bus.key[1] !== 1'b0 || bus.press[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce e%0d: key[1]=%b press[1]=%b, expected 0 0", e, bus.key[1], bus.press[1]);
            end
            n_tests++;
            if (bus.key !== m_key || bus.press !== m_press) begin
                n_fail++;
                $display("FAIL model_bounce e%0d: key=%b press=%b, expected key=%b press=%b", e, bus.key, bus.press, m_key, m_press);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic ek, ep;
        bus.key_n = 4'b1011;
        for (int e = 1; e <= 5; e++) begin
            tick();
            n_tests++;
            if (bus.key[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_count_pre e%0d: key[2]=%b, expected 0", e, bus.key[2]);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (bus.key !== 4'h0 || bus.press !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_count_rst: key=%b press=%b, expected 0000 0000", bus.key, bus.press);
        end
        for (int e = 1; e <= 7; e++) begin
            tick();
            ek = (e >= 6);
            ep = (e == 6);
            n_tests++;
            if (bus.key[2] !== ek || bus.press[2] !== ep) begin
                n_fail++;
                $display("FAIL mid_count_post e%0d: key[2]=%b press[2]=%b, expected %b %b", e, bus.key[2], bus.press[2], ek, ep);
            end
            n_tests++;
            if (bus.key !== m_key || bus.press !== m_press) begin
                n_fail++;
                $display("FAIL model_mid_count e%0d: key=%b press=%b, expected key=%b press=%b", e, bus.key, bus.press, m_key, m_press);
            end
        end
        bus.key_n = 4'hF;
        for (int e = 1; e <= 8; e++) tick();
        n_tests++;
        if (bus.key !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_count_release: key=%b, expected 0000", bus.key);
        end
    endtask

    task automatic test_autorepeat();
        int  rel;
        logic ek, ep;
        bus.key_n = 4'b0111;
        for (int e = 1; e <= 38; e++) begin
            if (e == 27) bus.key_n = 4'b1111;
            tick();
            rel = e - 6;
            ek = (e >= 6 && e < 32);
            ep = (rel == 0) || (AR && rel >= RD && ((rel - RD) % RP) == 0 && e < 32);
            n_tests++;
            if (bus.key[3] !== ek || bus.press[3] !== ep) begin
                n_fail++;
                $display("FAIL autorepeat e%0d: key[3]=%b press[3]=%b, expected %b %b", e, bus.key[3], bus.press[3], ek, ep);
            end
            n_tests++;
            if (bus.key !== m_key || bus.press !== m_press) begin
                n_fail++;
                $display("FAIL model_autorepeat e%0d: key=%b press=%b, expected key=%b press=%b", e, bus.key, bus.press, m_key, m_press);
            end
        end
    endtask

    task automatic test_random();
        int         hold[4];
        logic [3:0] kn;
        kn = 4'hF;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    kn[i]   = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 14));
                end
                hold[i]--;
            end
            bus.key_n = kn;
            rst = ($urandom_range(0, 99) == 0);
            tick();
            n_tests++;
            if (bus.key !== m_key || bus.press !== m_press) begin
                n_fail++;
                $display("FAIL random c%0d: key=%b press=%b, expected key=%b press=%b", c, bus.key, bus.press, m_key, m_press);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.key_n = 4'hF;
        model_reset();
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_reset_mid_count();
        test_autorepeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
